// File: rtl/ahb_arbiter_param.sv
// AHB bus arbiter: fixed, dynamic-priority or round-robin selection.
// Grants are held for a whole burst; release re-arbitrates with no idle gap.
module ahb_arbiter_param #(
    parameter int MASTER_NUM     = 4,
    parameter int PRIOR_LEVEL    = 4,
    parameter int ARB_MODE       = 0,
    parameter int INCR_MAX_BEATS = 16,
    localparam int PRIOR_BIT     = (PRIOR_LEVEL > 1) ? $clog2(PRIOR_LEVEL) : 1,
    localparam int MW            = $clog2(MASTER_NUM)
) (
    input  logic                                 hclk,
    input  logic                                 hreset,
    input  logic [MASTER_NUM-1:0]                hreq,
    input  logic [MASTER_NUM-1:0][2:0]           hburst,
    input  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] hprior,
    input  logic                                 hwait,
    output logic [MASTER_NUM-1:0]                hgrant,
    output logic                                 hsel,
    output logic [MW-1:0]                        hmaster,
    output logic                                 hlast
);

    localparam int MAXB = (INCR_MAX_BEATS > 16) ? INCR_MAX_BEATS : 16;
    localparam int CW   = $clog2(MAXB + 1);

    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] WRAP4  = 3'd2;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] WRAP8  = 3'd4;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] WRAP16 = 3'd6;
    localparam logic [2:0] INCR16 = 3'd7;

    typedef enum logic {IDLE, OWN} state_t;

    state_t                state, state_d;
    logic [MASTER_NUM-1:0] grant_d;
    logic [MW-1:0]         master_d;
    logic [CW-1:0]         count, count_d;
    logic [CW-1:0]         limit, limit_d;
    logic [2:0]            burst, burst_d;
    logic [MW-1:0]         last_winner, last_winner_d;

    logic [MW-1:0]         fix_win, dyn_win, rr_win, win;
    logic                  any_req, release_now;

    function automatic logic [CW-1:0] beat_limit(input logic [2:0] b);
        logic [CW-1:0] r;
        r = CW'(1);
        unique case (1'b1)
            (b == SINGLE):                r = CW'(1);
            (b == INCR):                  r = CW'(INCR_MAX_BEATS);
            (b == WRAP4  || b == INCR4):  r = CW'(4);
            (b == WRAP8  || b == INCR8):  r = CW'(8);
            (b == WRAP16 || b == INCR16): r = CW'(16);
            default:                      r = CW'(1);
        endcase
        return r;
    endfunction

    assign any_req = |hreq;

    always_comb begin
        fix_win = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (hreq[i]) fix_win = MW'(i);
        end
    end

    // Strict '>' keeps the lowest index on priority ties.
    always_comb begin
        logic                 found;
        logic [PRIOR_BIT-1:0] best;
        dyn_win = '0;
        found   = 1'b0;
        best    = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (hreq[i] && (!found || hprior[i] > best)) begin
                found   = 1'b1;
                best    = hprior[i];
                dyn_win = MW'(i);
            end
        end
    end

    always_comb begin
        logic found;
        int   j;
        rr_win = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            j = (int'(last_winner) + k) % MASTER_NUM;
            if (!found && hreq[j]) begin
                found  = 1'b1;
                rr_win = MW'(j);
            end
        end
    end

    always_comb begin
        if (ARB_MODE == 1)      win = dyn_win;
        else if (ARB_MODE == 2) win = rr_win;
        else                    win = fix_win;
    end

    assign hlast = (state == OWN) &&
                   ((count == limit - CW'(1)) ||
                    (burst == INCR && !hreq[hmaster]));

    assign release_now = hlast && !hwait;
    assign hsel        = |hgrant;

    always_comb begin
        state_d       = state;
        grant_d       = hgrant;
        master_d      = hmaster;
        count_d       = count;
        limit_d       = limit;
        burst_d       = burst;
        last_winner_d = last_winner;
        if (any_req && (state == IDLE || release_now)) begin
            state_d       = OWN;
            grant_d       = MASTER_NUM'(1) << win;
            master_d      = win;
            count_d       = '0;
            limit_d       = beat_limit(hburst[win]);
            burst_d       = hburst[win];
            last_winner_d = win;
        end else if (release_now) begin
            state_d  = IDLE;
            grant_d  = '0;
            master_d = '0;
            count_d  = '0;
        end else if (state == OWN && !hwait) begin
            count_d = count + CW'(1);
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= IDLE;
            hgrant      <= '0;
            hmaster     <= '0;
            count       <= '0;
            limit       <= CW'(1);
            burst       <= SINGLE;
            last_winner <= MW'(MASTER_NUM - 1);
        end else begin
            state       <= state_d;
            hgrant      <= grant_d;
            hmaster     <= master_d;
            count       <= count_d;
            limit       <= limit_d;
            burst       <= burst_d;
            last_winner <= last_winner_d;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Bench for ahb_arbiter_param: one instance per arbitration mode,
// vector table, directed corner sequences and a random model run.
module tb_ahb_arbiter_param;

    logic             hclk = 1'b0;
    logic             hreset;
    logic [3:0]       hreq;
    logic [3:0][2:0]  hburst;
    logic [3:0][1:0]  hprior;
    logic             hwait;

    logic [3:0] g   [3];
    logic       s   [3];
    logic [1:0] mst [3];
    logic       l   [3];

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter_param #(.MASTER_NUM(4), .PRIOR_LEVEL(4), .ARB_MODE(0),
                        .INCR_MAX_BEATS(16)) u_fix (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst),
        .hprior(hprior), .hwait(hwait), .hgrant(g[0]), .hsel(s[0]),
        .hmaster(mst[0]), .hlast(l[0]));

    ahb_arbiter_param #(.MASTER_NUM(4), .PRIOR_LEVEL(4), .ARB_MODE(1),
                        .INCR_MAX_BEATS(16)) u_dyn (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst),
        .hprior(hprior), .hwait(hwait), .hgrant(g[1]), .hsel(s[1]),
        .hmaster(mst[1]), .hlast(l[1]));

    ahb_arbiter_param #(.MASTER_NUM(4), .PRIOR_LEVEL(4), .ARB_MODE(2),
                        .INCR_MAX_BEATS(16)) u_rr (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst),
        .hprior(hprior), .hwait(hwait), .hgrant(g[2]), .hsel(s[2]),
        .hmaster(mst[2]), .hlast(l[2]));

    // Reference model: owner index (-1 idle), beats done, beats needed.
    int m_owner [3];
    int m_beats [3];
    int m_need  [3];
    bit m_incr  [3];
    int m_last  [3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int need_of(input int b);
        if (b == 0) return 1;
        if (b == 1) return 16;
        return 4 << ((b - 2) / 2);
    endfunction

    function automatic int pick(input int m);
        int best = -1;
        int bs   = -1;
        int sc;
        int i;
        for (int k = 0; k < 4; k++) begin
            if (m == 2) i = (m_last[2] + 1 + k) % 4;
            else        i = k;
            if (hreq[i]) begin
                sc = (m == 1) ? int'(hprior[i]) * 4 + (3 - i) : 4 - k;
                if (sc > bs) begin
                    bs   = sc;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic bit model_last(input int m);
        if (m_owner[m] < 0) return 1'b0;
        return (m_beats[m] == m_need[m] - 1) ||
               (m_incr[m] && !hreq[m_owner[m]]);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_owner[m] = -1;
            m_beats[m] = 0;
            m_need[m]  = 1;
            m_incr[m]  = 1'b0;
            m_last[m]  = 3;
        end
    endtask

    task automatic model_grant(input int m);
        int w;
        w          = pick(m);
        m_owner[m] = w;
        m_beats[m] = 0;
        m_need[m]  = need_of(int'(hburst[w]));
        m_incr[m]  = (hburst[w] == 3'd1);
        m_last[m]  = w;
    endtask

    task automatic model_update();
        bit fin;
        if (hreset) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 3; m++) begin
            fin = model_last(m);
            if (m_owner[m] < 0) begin
                if (hreq != 0) model_grant(m);
            end else if (!hwait) begin
                if (fin) begin
                    if (hreq != 0) model_grant(m);
                    else           m_owner[m] = -1;
                end else begin
                    m_beats[m]++;
                end
            end
        end
    endtask

    task automatic model_check();
        int own;
        for (int m = 0; m < 3; m++) begin
            own = m_owner[m];
            chk($sformatf("m%0d_grant", m), int'(g[m]),
                (own >= 0) ? (1 << own) : 0);
            chk($sformatf("m%0d_master", m), int'(mst[m]),
                (own >= 0) ? own : 0);
            chk($sformatf("m%0d_sel", m), int'(s[m]), int'(own >= 0));
            chk($sformatf("m%0d_last", m), int'(l[m]), int'(model_last(m)));
        end
    endtask

    task automatic tick_begin();
        @(negedge hclk);
        model_check();
    endtask

    task automatic tick_end();
        model_update();
        @(posedge hclk);
        #1;
    endtask

    task automatic tick();
        tick_begin();
        tick_end();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [2:0] burst;
        logic       wt;
        logic [3:0] grant;
        logic [1:0] mst;
        logic       last;
    } vec_t;

    vec_t tbl [13];
    int   rr_exp [6];

    initial begin
        tbl[0]  = '{4'b1010, 3'd0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 3'd0, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{4'b0000, 3'd0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{4'b0100, 3'd3, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[4]  = '{4'b0100, 3'd3, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[5]  = '{4'b0100, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[6]  = '{4'b0000, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[7]  = '{4'b0000, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[8]  = '{4'b0001, 3'd3, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[9]  = '{4'b0001, 3'd3, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[10] = '{4'b0001, 3'd0, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[11] = '{4'b0000, 3'd0, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[12] = '{4'b0000, 3'd0, 1'b0, 4'b0000, 2'd0, 1'b0};
        rr_exp  = '{0, 1, 2, 4, 8, 1};

        hreset = 1'b1;
        hreq   = '0;
        hburst = '0;
        hprior = '0;
        hwait  = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        model_reset();

        tick_begin();
        chk("rst_grant", int'(g[0]), 0);
        chk("rst_sel", int'(s[0]), 0);
        chk("rst_master", int'(mst[0]), 0);
        chk("rst_last", int'(l[0]), 0);
        chk("rst_count", int'(u_fix.count), 0);
        tick_end();
        hreset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            hreq   = tbl[i].req;
            hburst = {4{tbl[i].burst}};
            hwait  = tbl[i].wt;
            tick_begin();
            chk($sformatf("tbl%0d_grant", i), int'(g[0]), int'(tbl[i].grant));
            chk($sformatf("tbl%0d_master", i), int'(mst[0]), int'(tbl[i].mst));
            chk($sformatf("tbl%0d_last", i), int'(l[0]), int'(tbl[i].last));
            tick_end();
        end

        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        hreq   = 4'hf;
        hburst = '0;
        for (int k = 0; k < 6; k++) begin
            tick_begin();
            chk($sformatf("rr_seq%0d", k), int'(g[2]), rr_exp[k]);
            tick_end();
        end
        hreq = '0;
        tick();
        tick();

        hprior = {2'd3, 2'd1, 2'd3, 2'd0};
        hreq   = 4'hf;
        tick();
        tick_begin();
        chk("dyn_master", int'(mst[1]), 1);
        chk("dyn_grant", int'(g[1]), 2);
        tick_end();
        hreq = '0;
        tick();
        tick();

        hreq   = 4'b0001;
        hburst = {4{3'd1}};
        tick();
        for (int b = 1; b <= 16; b++) begin
            tick_begin();
            chk($sformatf("incr_grant%0d", b), int'(g[0]), 1);
            chk($sformatf("incr_last%0d", b), int'(l[0]), int'(b == 16));
            tick_end();
        end
        for (int b = 1; b <= 5; b++) begin
            if (b == 5) hreq = '0;
            tick_begin();
            chk($sformatf("drop_grant%0d", b), int'(g[0]), 1);
            chk($sformatf("drop_last%0d", b), int'(l[0]), int'(b == 5));
            tick_end();
        end
        tick_begin();
        chk("drop_release", int'(g[0]), 0);
        tick_end();

        hreq   = 4'b0001;
        hburst = {4{3'd5}};
        tick();
        tick();
        tick();
        tick_begin();
        chk("abort_beat3_grant", int'(g[0]), 1);
        hreset = 1'b1;
        hreq   = '0;
        tick_end();
        hreset = 1'b0;
        tick_begin();
        chk("abort_grant", int'(g[0]), 0);
        chk("abort_sel", int'(s[0]), 0);
        chk("abort_last", int'(l[0]), 0);
        chk("abort_count", int'(u_fix.count), 0);
        tick_end();

        for (int c = 0; c < 3000; c++) begin
            hreset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 0) hreq = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                hburst[i] = 3'($urandom_range(0, 7));
                hprior[i] = 2'($urandom_range(0, 3));
            end
            hwait = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
